// File: rtl/arbiter_pkg.sv
// Shared constants and types for the per-output-port credit round-robin arbiter.
// Index order in every 5-bit port vector is N, E, W, S, L.
package arbiter_pkg;

  localparam int NPORTS = 5;

  localparam logic [2:0] P_N = 3'd0;
  localparam logic [2:0] P_E = 3'd1;
  localparam logic [2:0] P_W = 3'd2;
  localparam logic [2:0] P_S = 3'd3;
  localparam logic [2:0] P_L = 3'd4;

  localparam logic [4:0] SEL_N = 5'b00001;
  localparam logic [4:0] SEL_E = 5'b00010;
  localparam logic [4:0] SEL_W = 5'b00100;
  localparam logic [4:0] SEL_S = 5'b01000;
  localparam logic [4:0] SEL_L = 5'b10000;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Port after p, wrapping L back to N.
  function automatic logic [2:0] next_port(input logic [2:0] p);
    return (p >= P_L) ? P_N : p + 3'd1;
  endfunction

  function automatic logic [4:0] onehot(input logic [2:0] p);
    return SEL_N << p;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr,
// wrapping from L back to N.
module rr_pick
  import arbiter_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic [2:0] winner,
  output logic       any
);

  logic [3:0] idx;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    winner = ptr;
    any    = |req;
    idx    = '0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= 4'(NPORTS)) begin
        idx = idx - 4'(NPORTS);
      end
      if (req[idx[2:0]]) begin
        winner = idx[2:0];
      end
    end
  end

endmodule

// File: rtl/credit_rr_arbiter.sv
// Wormhole round-robin arbiter for one output port, with downstream credit
// counting and one-hot crossbar select.
module credit_rr_arbiter
  import arbiter_pkg::*;
#(
  parameter int CREDITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req,
  input  logic [4:0] tail,
  input  logic       credit_in,
  output logic [4:0] grant,
  output logic [4:0] xbar_sel,
  output logic       valid_out,
  output logic [3:0] credit_cnt,
  output logic       credit_err
);

  localparam logic [3:0] CREDIT_MAX = 4'(CREDITS);

  state_t     state_reg, state_next;
  logic [2:0] owner_reg, owner_next;
  logic [2:0] ptr_reg, ptr_next;
  logic [3:0] credit_cnt_reg, credit_cnt_next;
  logic       credit_err_reg, credit_err_next;

  logic [2:0] pick_winner;
  logic       pick_any;
  logic       has_credit;
  logic [4:0] sel;
  logic [4:0] grant_int;

  rr_pick u_pick (
    .req    (req),
    .ptr    (ptr_reg),
    .winner (pick_winner),
    .any    (pick_any)
  );

  assign has_credit = (credit_cnt_reg != 4'd0);

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    sel        = '0;
    grant_int  = '0;
    case (state_reg)
      IDLE: begin
        if (pick_any && has_credit) begin
          owner_next = pick_winner;
          state_next = LOCKED;
        end
      end
      LOCKED: begin
        sel       = onehot(owner_reg);
        // Only the owner can ever be granted; a stalled owner keeps the lock.
        grant_int = sel & req & {5{has_credit}};
        if (|(grant_int & tail)) begin
          state_next = IDLE;
          ptr_next   = next_port(owner_reg);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    credit_cnt_next = credit_cnt_reg;
    credit_err_next = credit_err_reg;
    case ({|grant_int, credit_in})
      2'b10: credit_cnt_next = credit_cnt_reg - 4'd1;
      2'b01: begin
        if (credit_cnt_reg >= CREDIT_MAX) begin
          credit_err_next = 1'b1;
        end else begin
          credit_cnt_next = credit_cnt_reg + 4'd1;
        end
      end
      default: credit_cnt_next = credit_cnt_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= P_N;
      ptr_reg        <= P_N;
      credit_cnt_reg <= CREDIT_MAX;
      credit_err_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      ptr_reg        <= ptr_next;
      credit_cnt_reg <= credit_cnt_next;
      credit_err_reg <= credit_err_next;
    end
  end

  assign grant      = grant_int;
  assign xbar_sel   = sel;
  assign valid_out  = |grant_int;
  assign credit_cnt = credit_cnt_reg;
  assign credit_err = credit_err_reg;

endmodule

// File: doc/credit_rr_arbiter.md
# credit_rr_arbiter

Packet-level round-robin arbiter with credit-based flow control for one router output port. It shares the output among the five input requesters (N, E, W, S, L) and holds a grant for a whole packet, head to tail (wormhole). It also drives the one-hot crossbar select, and it counts downstream buffer credits in place of the single RTS/DCTS handshake. One instance sits per output port, between the input buffers and the crossbar.

## Interface
Parameters:
- CREDITS, 4: downstream buffer depth and reset value of the credit counter. Legal range 1..15.

Ports. Bit index in every 5-bit vector: 0=N, 1=E, 2=W, 3=S, 4=L.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req  in  5  requester i has a flit at its buffer head.
- tail  in  5  the head flit of requester i is a packet tail. Meaningful only while req[i]=1.
- credit_in  in  1  one-cycle pulse: downstream freed one slot.
- grant  out  5  one-hot or zero. grant[i]=1 means requester i's flit transfers this cycle.
- xbar_sel  out  5  one-hot owner select. Zero when idle.
- valid_out  out  1  OR of grant. A flit is written downstream this cycle.
- credit_cnt  out  4  current credit count.
- credit_err  out  1  sticky: credit_in arrived while credit_cnt=CREDITS.

## Operation
- FSM states:
  - IDLE: no owner.
  - LOCKED: owner register holds one index.
- IDLE behaviour:
  - xbar_sel=0 and grant=0.
  - If req≠0 and credit_cnt>0, a round-robin search picks the first set req bit. The search starts at index ptr and goes upward, wrapping 4→0.
  - The winner is loaded into owner. Next state is LOCKED.
- LOCKED behaviour:
  - xbar_sel=onehot(owner).
  - grant[owner] = req[owner] & (credit_cnt>0). All other grant bits are 0.
  - If grant[owner]=1 and tail[owner]=1: next state is IDLE and ptr=(owner+1) mod 5.
  - If the owner deasserts req mid-packet, the FSM stays LOCKED with grant=0. There is no timeout and no pre-emption.
- Credit counter:
  - Decrements on valid_out and increments on credit_in.
  - If both occur in one cycle, the count is unchanged.
  - It never goes below 0, because grant is gated by credit_cnt>0.
  - credit_in at credit_cnt=CREDITS (without a simultaneous transfer) leaves the count at CREDITS and sets credit_err=1.
  - credit_err clears only on reset.
- Arithmetic: 4-bit unsigned counter, no wrap.
- Reset values:
  - state=IDLE, owner=0, ptr=0 (N first).
  - credit_cnt=CREDITS, credit_err=0.
  - grant=0, xbar_sel=0, valid_out=0.

## Timing
- Arbitration latency: req sampled in IDLE at edge k gives LOCKED and the first grant possible in cycle k+1. grant is combinational from req and credit_cnt within LOCKED.
- Throughput:
  - One flit per cycle while locked, provided req is held and credits remain.
  - After a tail, there is one IDLE cycle before the next packet's first grant.
  - A single-flit packet therefore takes 2 cycles.
- Credit updates take effect on the next edge. A transfer that consumes the last credit blocks the grant in the following cycle.
- A credit_in arriving in the same cycle as credit_cnt=0 produces grant in the next cycle, not the same cycle.
- rst asserted mid-packet:
  - All outputs go to their reset values immediately, asynchronously.
  - The abandoned packet is not resumed. The owner must re-arbitrate after reset deassertion.
  - Reset deassertion is synchronised externally.

## Structure
- Package arbiter_pkg holds:
  - Port index constants P_N..P_L (0..4) and NPORTS=5.
  - One-hot select constants SEL_N=5'b00001 … SEL_L=5'b10000.
  - State enum {IDLE, LOCKED}.
- Sub-module rr_pick: purely combinational.
  - Inputs: req[4:0] and ptr[2:0].
  - Outputs: winner index[2:0] and any flag.
  - Reused by the other per-output instances.
- The top module contains the FSM, the owner/ptr registers and the credit counter.

## Test plan
- Priority and rotation:
  - After reset, req=5'b10001 (N and L), tail=all 1 → N is granted first.
  - Then ptr=1, so L is granted in the next packet.
  - N is granted again only after L's tail.
- Wormhole hold:
  - E owns; packet is 3 flits, tail on the 3rd.
  - Other req bits are held at 1 throughout.
  - Required: grant=5'b00010 for 3 consecutive cycles, xbar_sel=5'b00010, then one IDLE cycle.
- Credit exhaustion:
  - CREDITS=2, no credit_in, 4-flit packet from W.
  - Required: 2 grants, then grant=0 with state LOCKED and credit_cnt=0.
  - A credit_in pulse gives one grant on the next cycle.
- Simultaneous events:
  - A transfer and credit_in in the same cycle leave credit_cnt unchanged.
  - credit_in at credit_cnt=CREDITS sets credit_err=1, which stays set.
- Owner stall: the S owner drops req for 3 cycles mid-packet. Required: grant=0, xbar_sel=5'b01000, and no other port granted.
- Reset mid-packet: assert rst between clock edges while L is locked. Required: grant, xbar_sel and valid_out=0 immediately, credit_cnt=CREDITS, and ptr back to N.
